// File: rtl/io_extend_spi_master.sv
// io_extend_spi_master
// Upstream SPI master for io_extend. A parallel word arrives over a
// valid/ready handshake and is shifted out LSB-first on SI/SCK, framed by an
// active-high SS. Each frame runs IDLE -> SETUP -> (HIGH <-> LOW) -> GAP -> IDLE.
// Optional feature: define IO_EXTEND_READBACK_EN to build SO capture logic.
// Without that macro, rx_data and rx_valid are tied to 0 and SO is ignored.
module io_extend_spi_master #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 2,
    parameter int SS_GAP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             done,
    output logic             SS,
    output logic             SCK,
    output logic             SI,
    input  logic             SO,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    localparam int PH_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam int BIT_W  = $clog2(WIDTH) + 1;

    localparam logic [PH_W-1:0]  DIV_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(SS_GAP - 1);
    // The bit counter is bumped on LOW entry, so it reads WIDTH during the
    // low phase of the final bit.
    localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [BIT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift;

    // Frame sequencer: every serial output is registered directly in the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_ready <= 1'b1;
            done     <= 1'b0;
            SS       <= 1'b0;
            SCK      <= 1'b0;
            SI       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shift    <= tx_data;
                        bit_cnt  <= '0;
                        phase    <= '0;
                        SS       <= 1'b1;
                        SCK      <= 1'b0;
                        SI       <= tx_data[0];
                        tx_ready <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase == DIV_LAST) begin
                        phase <= '0;
                        SCK   <= 1'b1;
                        state <= HIGH;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase == DIV_LAST) begin
                        // Falling SCK: present the next bit for the following rise
                        phase   <= '0;
                        SCK     <= 1'b0;
                        shift   <= {1'b0, shift[WIDTH-1:1]};
                        SI      <= shift[1];
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= LOW;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                LOW: begin
                    if (phase == DIV_LAST) begin
                        phase <= '0;
                        if (bit_cnt == BIT_END) begin
                            SS    <= 1'b0;
                            SI    <= 1'b0;
                            done  <= 1'b1;
                            state <= GAP;
                        end else begin
                            SCK   <= 1'b1;
                            state <= HIGH;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                GAP: begin
                    if (phase == GAP_LAST) begin
                        phase    <= '0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IO_EXTEND_READBACK_EN
    logic [WIDTH-1:0] rx_shift;

    // SO capture: one sample per bit in the first HIGH cycle, published with done
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == HIGH && phase == '0) begin
                rx_shift <= {SO, rx_shift[WIDTH-1:1]};
            end
            if (state == LOW && phase == DIV_LAST && bit_cnt == BIT_END) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_so;
    assign unused_so = SO;
    assign rx_data   = '0;
    assign rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_io_extend_spi_master.sv
// tb_io_extend_spi_master
// Scoreboard bench: the stimulus side pushes every accepted word into a queue;
// a monitor acting as the io_extend shift register rebuilds each frame from
// SI on SCK rising edges and checks it when done pulses.
// SO is looped back to SI; readback expectations follow IO_EXTEND_READBACK_EN.
`timescale 1ns/1ps
module tb_io_extend_spi_master;

    localparam int WIDTH   = 16;
    localparam int CLK_DIV = 2;
    localparam int SS_GAP  = 4;
    localparam int SS_HIGH = CLK_DIV * (1 + 2 * WIDTH);
    localparam int SPACING = SS_HIGH + SS_GAP + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] tx_data = '0;
    logic             tx_valid = 1'b0;
    logic             tx_ready, done, SS, SCK, SI, SO;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;

    assign SO = SI;

    always #5 clk = ~clk;

    io_extend_spi_master #(
        .WIDTH  (WIDTH),
        .CLK_DIV(CLK_DIV),
        .SS_GAP (SS_GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .done    (done),
        .SS      (SS),
        .SCK     (SCK),
        .SI      (SI),
        .SO      (SO),
        .rx_data (rx_data),
        .rx_valid(rx_valid)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [WIDTH-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic             ss_prev = 1'b0;
    logic             sck_prev = 1'b0;
    int               edges = 0;
    int               ss_hi = 0;
    logic [WIDTH-1:0] rx_word = '0;
    logic [WIDTH-1:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            edges   = 0;
            ss_hi   = 0;
            rx_word = '0;
        end else begin
            if (SS && SCK && !sck_prev) begin
                if (edges < WIDTH) rx_word[edges] = SI;
                edges++;
            end
            if (SS) ss_hi++;
            if (rx_valid && !done) check("rx_valid_without_done", {31'b0, rx_valid}, 32'd0);
            if (done) begin
                check("done_on_ss_fall", {30'b0, ss_prev, SS}, 32'd2);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_frame: got word %0h, expected no frame", rx_word);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("frame_word", rx_word, exp_w);
                    check("frame_sck_edges", edges, WIDTH);
                    check("frame_ss_high_cycles", ss_hi, SS_HIGH);
`ifdef IO_EXTEND_READBACK_EN
                    check("rx_valid_with_done", {31'b0, rx_valid}, 32'd1);
                    check("rx_data", rx_data, exp_w);
`else
                    check("rx_valid_disabled", {31'b0, rx_valid}, 32'd0);
                    check("rx_data_disabled", rx_data, 32'd0);
`endif
                end
                edges = 0;
                ss_hi = 0;
            end else if (ss_prev && !SS) begin
                edges = 0;
                ss_hi = 0;
            end
        end
        ss_prev  = SS;
        sck_prev = SCK;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [WIDTH-1:0] w, input bit hold, input bit expect_frame,
                        output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = 0;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got tx_ready=0, expected 1 within 2000 cycles");
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (expect_frame) exp_q.push_back(w);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(tx_ready && exp_q.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout: got %0d frames pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1, a2, k, n, ss_seen;
        logic sck_p;

        // Reset held for 3 clocks
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_ss", {31'b0, SS}, 32'd0);
        check("reset_sck", {31'b0, SCK}, 32'd0);
        check("reset_si", {31'b0, SI}, 32'd0);
        check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("reset_rx_data", rx_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single MSB-only word
        send(16'h8000, 1'b0, 1'b1, a1);
        wait_idle();

        // Back-to-back with tx_valid held high
        send(16'h0001, 1'b1, 1'b1, a1);
        send(16'hFFFF, 1'b0, 1'b1, a2);
        check("accept_spacing", a2 - a1, SPACING);
        wait_idle();

        // Reset after the 5th SCK rising edge
        send(16'h5A5A, 1'b0, 1'b0, a1);
        k = 0;
        n = 0;
        sck_p = 1'b0;
        while (k < 5 && n < 500) begin
            @(negedge clk);
            if (SCK && !sck_p) k++;
            sck_p = SCK;
            n++;
        end
        check("reset_wait_5_edges", k, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_ss", {31'b0, SS}, 32'd0);
        check("midreset_sck", {31'b0, SCK}, 32'd0);
        check("midreset_si", {31'b0, SI}, 32'd0);
        check("midreset_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("midreset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        tx_data  = 16'h3C96;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("accept_after_reset", {31'b0, tx_ready}, 32'd0);
        exp_q.push_back(16'h3C96);
        tx_valid = 1'b0;
        wait_idle();

        // tx_valid pulsed while busy must be ignored
        send(16'h0F0F, 1'b0, 1'b1, a1);
        repeat (10) @(negedge clk);
        tx_data  = 16'h1234;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = '0;
        wait_idle();
        ss_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (SS) ss_seen++;
        end
        check("no_extra_frame", ss_seen, 0);

        // Readback word with SO looped to SI
        send(16'hA5C3, 1'b0, 1'b1, a1);
        wait_idle();
        repeat (5) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
